mem_bus_arbiter: RTL

Round-robin arbiter and sequencer that shares the single cache-to-memory bus controller among `NREQ` cache requesters. It selects one pending load/store request, presents it to the downstream bus controller with a valid/ready handshake, and tracks the transaction to completion. It returns a per-requester done pulse, or an error pulse when the bus fails to complete within `TIMEOUT` cycles. It sits between the L1 caches and the AXI bus controller, and gates new grants while a coherence snoop is being serviced.

---
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter_if
//
// Command/completion channel between the memory bus arbiter and the
// downstream cache-to-memory bus controller.
//
//   dn_valid  arbiter -> ctrl  command valid (held until dn_ready)
//   dn_ready  ctrl -> arbiter  command accepted
//   dn_store  arbiter -> ctrl  1 = store, 0 = load
//   dn_addr   arbiter -> ctrl  transaction address
//   dn_id     arbiter -> ctrl  requester index owning the transaction
//   dn_done   ctrl -> arbiter  one-cycle transaction-complete pulse
//
// Modports: master = arbiter side, slave = bus controller side.
// ----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 64
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                  dn_valid;
    logic                  dn_ready;
    logic                  dn_store;
    logic [ADDR_WIDTH-1:0] dn_addr;
    logic [IDW-1:0]        dn_id;
    logic                  dn_done;

    modport master (
        output dn_valid, dn_store, dn_addr, dn_id,
        input  dn_ready, dn_done
    );

    modport slave (
        input  dn_valid, dn_store, dn_addr, dn_id,
        output dn_ready, dn_done
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Round-robin arbiter/sequencer sharing one cache-to-memory bus controller
// among NREQ cache requesters. One request is granted at a time, issued on
// the dn channel with a valid/ready handshake, and tracked until dn_done or
// until TIMEOUT cycles pass, after which the owner gets a done (+err) pulse.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   req_valid     per-requester request pending (held until req_done)
//   req_store     per-requester 1 = store, 0 = load
//   req_addr      per-requester address, packed [NREQ-1:0][ADDR_WIDTH-1:0]
//   req_grant     one-hot owner from ISSUE through RESP
//   req_done      one-cycle completion pulse to the owner
//   req_err       one-cycle pulse with req_done when the transaction timed out
//   snoop_hold    blocks new grants while high (in-flight work continues)
//   dn            master side of mem_bus_arbiter_if (bus controller channel)
//   busy          high whenever the sequencer is not idle
//   timeout_flag  sticky timeout indicator, cleared only by reset
//
// All outputs decode registered state/latches; no input-to-output paths.
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NREQ-1:0]                  req_valid,
    input  logic [NREQ-1:0]                  req_store,
    input  logic [NREQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    output logic [NREQ-1:0]                  req_grant,
    output logic [NREQ-1:0]                  req_done,
    output logic [NREQ-1:0]                  req_err,
    input  logic                             snoop_hold,
    mem_bus_arbiter_if.master                dn,
    output logic                             busy,
    output logic                             timeout_flag
);

    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IDX_W = IDW + 1;
    // Counter must be able to hold TIMEOUT itself: when dn_ready wins on the
    // expiry cycle the transaction enters WAIT with the count already past
    // TIMEOUT-1, and the expiry test below is a >= so it fires on that WAIT
    // cycle instead of waiting for a wrap.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]          cur_id_q, cur_id_d;
    logic                    cur_store_q, cur_store_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    timeout_flag_q, timeout_flag_d;

    logic                    win_found;
    logic [IDW-1:0]          win_id;

    // Round-robin winner: first pending requester at or above rr_ptr,
    // wrapping modulo NREQ.
    always_comb begin
        logic [IDX_W-1:0] idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr_q} + IDX_W'(i);
            if (idx >= IDX_W'(NREQ)) begin
                idx = idx - IDX_W'(NREQ);
            end
            if (!win_found && req_valid[idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[IDW-1:0];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        cur_id_d       = cur_id_q;
        cur_store_d    = cur_store_q;
        cur_addr_d     = cur_addr_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        timeout_flag_d = timeout_flag_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_found && !snoop_hold) begin
                    state_d     = S_ISSUE;
                    cur_id_d    = win_id;
                    cur_store_d = req_store[win_id];
                    cur_addr_d  = req_addr[win_id];
                    cnt_d       = '0;
                    err_d       = 1'b0;
                end
            end

            S_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                // dn_ready takes precedence over expiry on the same cycle.
                if (dn.dn_ready) begin
                    state_d = S_WAIT;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d        = S_RESP;
                    err_d          = 1'b1;
                    timeout_flag_d = 1'b1;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // dn_done takes precedence over expiry on the same cycle.
                if (dn.dn_done) begin
                    state_d = S_RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d        = S_RESP;
                    err_d          = 1'b1;
                    timeout_flag_d = 1'b1;
                end
            end

            S_RESP: begin
                state_d  = S_IDLE;
                rr_ptr_d = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            cur_id_q       <= '0;
            cur_store_q    <= 1'b0;
            cur_addr_q     <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            cur_id_q       <= cur_id_d;
            cur_store_q    <= cur_store_d;
            cur_addr_q     <= cur_addr_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    // Per-requester outputs decoded from the registered owner id and state.
    always_comb begin
        req_grant = '0;
        req_done  = '0;
        req_err   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cur_id_q == IDW'(i)) begin
                req_grant[i] = (state_q != S_IDLE);
                req_done[i]  = (state_q == S_RESP);
                req_err[i]   = (state_q == S_RESP) && err_q;
            end
        end
    end

    assign dn.dn_valid  = (state_q == S_ISSUE);
    assign dn.dn_store  = cur_store_q;
    assign dn.dn_addr   = cur_addr_q;
    assign dn.dn_id     = cur_id_q;

    assign busy         = (state_q != S_IDLE);
    assign timeout_flag = timeout_flag_q;

endmodule
